// File: rtl/onehot_bus_reader_pkg.sv
// Shared types and default sizing for the one-hot AND-OR bus read master.
// No logic of its own; latency not applicable.
// No backpressure; constants and the FSM state encoding only.
package onehot_bus_reader_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_SETTLE = 1;

    // Encodings are fixed so waveforms and debug probes read the same across builds
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/onehot_bus_reader_addr_onehot_dec.sv
// Address to one-hot word-select decoder with an out-of-range flag.
// Purely combinational, zero latency.
// No backpressure; the caller registers the result.
module addr_onehot_dec #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DEPTH-1:0]  onehot_o,
    output logic              oor_o
);

    // One select per gated word; addresses past the last word match nothing
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            onehot_o[i] = (addr_i == ADDR_W'(i));
        end
    end

    // No select line matched means the address has no backing word
    assign oor_o = ~|onehot_o;

endmodule

// File: rtl/onehot_bus_reader.sv
// Read master for the gated AND-OR word bus: one-hot select, settle, capture, respond.
// Latency: request handshake edge N -> sel high N+1..N+SETTLE -> rsp_valid from N+SETTLE+1.
// Backpressure: a response beat holds while rsp_ready is low; sel stays released meanwhile.
module onehot_bus_reader
    import onehot_bus_reader_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    output logic [DEPTH-1:0]  sel,
    input  logic [WIDTH-1:0]  bus_d,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_last,
    output logic              rsp_err
);

    // Settle counter terminal value; the counter runs 0..SETTLE-1 while sel is driven
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   beats_q;
    logic [3:0]          cnt_q;
    logic [DEPTH-1:0]    sel_q;
    logic                oor_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [WIDTH-1:0]    rsp_data_q;
    logic                rsp_last_q;
    logic                rsp_err_q;

    logic [ADDR_W-1:0]   dec_addr;
    logic [DEPTH-1:0]    sel_d;
    logic                oor_d;

    // In IDLE the decoder looks at the incoming request; in HOLD it looks ahead to the next
    // beat (wrapping at 2**ADDR_W) so sel can be loaded on the response handshake edge
    assign dec_addr = (state_q == ST_IDLE) ? req_addr : ADDR_W'(addr_q + ADDR_W'(1));

    addr_onehot_dec #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_dec (
        .addr_i   (dec_addr),
        .onehot_o (sel_d),
        .oor_o    (oor_d)
    );

    // Read sequencer: IDLE -> DRIVE -> HOLD -> (DRIVE | IDLE), all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            beats_q     <= '0;
            cnt_q       <= '0;
            sel_q       <= '0;
            oor_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        addr_q      <= req_addr;
                        beats_q     <= req_len;
                        cnt_q       <= '0;
                        sel_q       <= sel_d;
                        oor_q       <= oor_d;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        // bus_d is only looked at on this edge; out-of-range beats return zero
                        rsp_data_q  <= oor_q ? '0 : bus_d;
                        rsp_err_q   <= oor_q;
                        rsp_last_q  <= (beats_q == '0);
                        rsp_valid_q <= 1'b1;
                        sel_q       <= '0;
                        state_q     <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (rsp_last_q) begin
                            req_ready_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            addr_q  <= dec_addr;
                            beats_q <= beats_q - ADDR_W'(1);
                            cnt_q   <= '0;
                            sel_q   <= sel_d;
                            oor_q   <= oor_d;
                            state_q <= ST_DRIVE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign sel       = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;

endmodule
